// File: rtl/lfsr_scrambler_stream.sv
// -----------------------------------------------------------------------------
// lfsr_scrambler_stream
//
// Handshaked stream scrambler/descrambler built around a programmable
// Fibonacci LFSR. Each accepted DATA_W-bit beat advances the LFSR DATA_W
// bit-steps, with bit 0 of the beat processed first. Three flavours are
// selected by MODE:
//   0 : additive (frame-synchronous). The keystream depends only on the LFSR.
//   1 : multiplicative scramble. Scrambled output bits feed the LFSR.
//   2 : multiplicative descramble. Received (scrambled) bits feed the LFSR,
//       so the descrambler self-synchronises after LFSR_W received bits.
// MODE values above 2 behave as additive.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    input beat valid
//   in_ready    block can accept an input beat (combinational)
//   in_data     input beat, bit 0 first
//   out_valid   output beat valid (registered)
//   out_ready   downstream accepts the output beat
//   out_data    scrambled/descrambled beat (registered)
//   bypass      accepted beat passes through unmodified
//   seed_load   single-cycle request to load seed_value into the LFSR
//   seed_value  LFSR seed
//   lfsr_zero   LFSR state is all-zero (registered)
// -----------------------------------------------------------------------------
module lfsr_scrambler_stream #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'b1001000,
  parameter logic [LFSR_W-1:0] SEED   = 7'h7F,
  parameter int unsigned       MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              bypass,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic              lfsr_zero
);

  // Out-of-range MODE folds onto additive.
  localparam logic [1:0] EFF_MODE = (MODE > 32'd2) ? 2'd0 : 2'(MODE);

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_MSCR  = 2'd1;
  localparam logic [1:0] MODE_MDSCR = 2'd2;

  // Unrolled DATA_W-step update. Returns {beat_out, next_state}.
  // In bypass the output is the raw input; the LFSR still advances so that
  // additive keystream alignment holds and multiplicative modes shift in the
  // line bits they would see on the wire.
  function automatic logic [DATA_W+LFSR_W-1:0] scramble_beat(
    input logic [LFSR_W-1:0] s_cur,
    input logic [DATA_W-1:0] din,
    input logic              byp
  );
    logic [LFSR_W-1:0] s_v;
    logic [DATA_W-1:0] o_v;
    logic              p_v;
    logic              fb_v;
    s_v = s_cur;
    o_v = '0;
    for (int j = 0; j < int'(DATA_W); j++) begin
      p_v = ^(s_v & TAPS);
      if (byp) begin
        o_v[j] = din[j];
      end else begin
        o_v[j] = din[j] ^ p_v;
      end
      case (EFF_MODE)
        MODE_MSCR:  fb_v = o_v[j];
        MODE_MDSCR: fb_v = din[j];
        MODE_ADD:   fb_v = p_v;
        default:    fb_v = p_v;
      endcase
      s_v = {s_v[LFSR_W-2:0], fb_v};
    end
    return {o_v, s_v};
  endfunction

  logic [LFSR_W-1:0] lfsr_r;
  logic              lfsr_zero_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;

  logic              in_ready_s;
  logic              accept_s;
  logic [LFSR_W-1:0] lfsr_next_s;
  logic [DATA_W-1:0] beat_out_s;

  // Handshake: a seed load owns the LFSR for its cycle, so no beat is taken.
  always_comb begin
    in_ready_s = !seed_load && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Combinational beat transform from the current LFSR state.
  always_comb begin
    {beat_out_s, lfsr_next_s} = scramble_beat(lfsr_r, in_data, bypass);
  end

  // LFSR state and zero flag; they only move on seed load or beat accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r      <= SEED;
      lfsr_zero_r <= (SEED == '0);
    end else if (seed_load) begin
      lfsr_r      <= seed_value;
      lfsr_zero_r <= (seed_value == '0);
    end else if (accept_s) begin
      lfsr_r      <= lfsr_next_s;
      lfsr_zero_r <= (lfsr_next_s == '0);
    end else begin
      lfsr_r      <= lfsr_r;
      lfsr_zero_r <= lfsr_zero_r;
    end
  end

  // Output register: load on accept, drop valid after a transfer with no
  // replacement, otherwise hold (stall keeps data stable).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= beat_out_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign lfsr_zero = lfsr_zero_r;

endmodule

// -----------------------------------------------------------------------------
// lfsr_scrambler_stream_chk
//
// Protocol checker for the stream ports of lfsr_scrambler_stream.
// Ports mirror the observed DUT signals; all are inputs.
// -----------------------------------------------------------------------------
module lfsr_scrambler_stream_chk #(
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  input logic              in_ready,
  input logic              out_valid,
  input logic              out_ready,
  input logic [DATA_W-1:0] out_data,
  input logic              seed_load
);

  // Ready is a pure function of seed_load and output-slot state.
  a_ready_eq: assert property (@(posedge clk) disable iff (rst)
    in_ready == (!seed_load && (!out_valid || out_ready)));

  // A stalled output beat stays valid and unchanged.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_lfsr_scrambler_stream.sv
module tb_lfsr_scrambler_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Additive instance (defaults)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic       a_bypass, a_seed_load, a_lfsr_zero;
  logic [6:0] a_seed_value;

  // Multiplicative scrambler -> descrambler pair
  logic       s_in_valid, s_in_ready, s_out_valid, d_in_ready, d_out_valid;
  logic [7:0] s_in_data, s_out_data, d_out_data;
  logic       s_lfsr_zero, d_lfsr_zero;

  lfsr_scrambler_stream u_add (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .bypass(a_bypass), .seed_load(a_seed_load), .seed_value(a_seed_value),
    .lfsr_zero(a_lfsr_zero)
  );

  lfsr_scrambler_stream_chk #(.DATA_W(8)) u_add_chk (
    .clk(clk), .rst(rst), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .seed_load(a_seed_load)
  );

  lfsr_scrambler_stream #(.MODE(1), .SEED(7'h7F)) u_scr (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(d_in_ready), .out_data(s_out_data),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00),
    .lfsr_zero(s_lfsr_zero)
  );

  lfsr_scrambler_stream #(.MODE(2), .SEED(7'h15)) u_dsc (
    .clk(clk), .rst(rst),
    .in_valid(s_out_valid), .in_ready(d_in_ready), .in_data(s_out_data),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_data(d_out_data),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00),
    .lfsr_zero(d_lfsr_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference additive scrambler for taps s[6]^s[3], written out per bit.
  task automatic ref_add(input logic [6:0] st_i, input logic [7:0] d,
                         output logic [7:0] o, output logic [6:0] st_o);
    logic [6:0] st;
    logic k;
    st = st_i;
    o  = 8'h00;
    for (int j = 0; j < 8; j++) begin
      k    = st[6] ^ st[3];
      o[j] = d[j] ^ k;
      st   = {st[5:0], k};
    end
    st_o = st;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    a_bypass = 1'b0; a_seed_load = 1'b0; a_seed_value = 7'h00;
    s_in_valid = 1'b0; s_in_data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] bp_data [7];
  logic [7:0] bp_exp  [7];
  logic [6:0] m_st, st_after0;
  logic [7:0] m_out;
  logic [7:0] rt_data [256];
  int rcv;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 8'h00);
    check("rst_lfsr_zero", a_lfsr_zero, 1'b0);
    check("rst_lfsr", u_add.lfsr_r, 7'h7F);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- additive vector: 0x00 beats ----------------
    a_in_valid = 1'b1; a_in_data = 8'h00; a_out_ready = 1'b1;
    @(negedge clk);
    check("add_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("add0_valid", a_out_valid, 1'b1);
    check("add0_data", a_out_data, 8'h70);
    check("add0_lfsr", u_add.lfsr_r, 7'h0E);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("add1_data", a_out_data, 8'h4F);
    check("add1_lfsr", u_add.lfsr_r, 7'h72);
    @(posedge clk); #1;
    @(negedge clk);
    check("add_valid_clear", a_out_valid, 1'b0);

    // ---------------- additive data: 0xFF beats ----------------
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'hFF;
    @(posedge clk); #1;
    @(negedge clk);
    check("ff0_data", a_out_data, 8'h8F);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("ff1_data", a_out_data, 8'hB0);

    // ---------------- backpressure ----------------
    do_reset();
    bp_data[0] = 8'h00; bp_data[1] = 8'h13; bp_data[2] = 8'hFF; bp_data[3] = 8'h80;
    bp_data[4] = 8'h5A; bp_data[5] = 8'h01; bp_data[6] = 8'hE7;
    m_st = 7'h7F;
    for (int i = 0; i < 7; i++) begin
      ref_add(m_st, bp_data[i], m_out, m_st);
      bp_exp[i] = m_out;
      if (i == 0) st_after0 = m_st;
    end
    a_in_valid = 1'b1; a_in_data = bp_data[0]; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_data = bp_data[1]; a_out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", a_out_valid, 1'b1);
      check("bp_hold_data", a_out_data, bp_exp[0]);
      check("bp_hold_ready", a_in_ready, 1'b0);
      check("bp_hold_lfsr", u_add.lfsr_r, st_after0);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      if (i < 6) a_in_data = bp_data[i+1];
      else a_in_valid = 1'b0;
      @(negedge clk);
      check("bp_stream_valid", a_out_valid, 1'b1);
      check("bp_stream_data", a_out_data, bp_exp[i]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drain", a_out_valid, 1'b0);

    // ---------------- seed load mid-stream ----------------
    ref_add(m_st, 8'h3C, m_out, m_st);
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    @(posedge clk); #1;
    a_seed_load = 1'b1; a_seed_value = 7'h7F; a_in_data = 8'h00;
    @(negedge clk);
    check("seed_in_ready", a_in_ready, 1'b0);
    check("seed_pending_data", a_out_data, m_out);
    @(posedge clk); #1;
    a_seed_load = 1'b0;
    @(negedge clk);
    check("seed_pending_gone", a_out_valid, 1'b0);
    check("seed_lfsr", u_add.lfsr_r, 7'h7F);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("seed_beat_data", a_out_data, 8'h70);

    // zero seed: keystream locks at zero
    a_seed_load = 1'b1; a_seed_value = 7'h00;
    @(posedge clk); #1;
    a_seed_load = 1'b0;
    @(negedge clk);
    check("zero_flag", a_lfsr_zero, 1'b1);
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    @(posedge clk); #1;
    a_in_data = 8'hC3;
    @(negedge clk);
    check("zero_data0", a_out_data, 8'h5A);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("zero_data1", a_out_data, 8'hC3);
    check("zero_flag_hold", a_lfsr_zero, 1'b1);

    // ---------------- async reset mid-stream, then bypass ----------------
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'h11; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", a_out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", a_out_valid, 1'b0);
    check("async_rst_lfsr", u_add.lfsr_r, 7'h7F);
    @(posedge clk); #1;
    rst = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_bypass = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_bypass = 1'b0; a_in_data = 8'h00;
    @(negedge clk);
    check("bypass_data", a_out_data, 8'hA5);
    check("bypass_lfsr", u_add.lfsr_r, 7'h0E);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("post_bypass_data", a_out_data, 8'h4F);

    // ---------------- self-synchronising round trip ----------------
    do_reset();
    rcv = 0;
    for (int i = 0; i < 262; i++) begin
      if (i < 256) begin
        rt_data[i] = 8'($urandom);
        s_in_valid = 1'b1;
        s_in_data  = rt_data[i];
      end else begin
        s_in_valid = 1'b0;
      end
      @(negedge clk);
      if (d_out_valid) begin
        if (rcv >= 1 && rcv < 256) check("roundtrip", d_out_data, rt_data[rcv]);
        rcv++;
      end
      @(posedge clk); #1;
    end
    check("roundtrip_count", rcv, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
